// File: rtl/axi_fifo_rr_arbiter.sv
// axi_fifo_rr_arbiter: round-robin arbiter sharing one AXI-stream FIFO write port between NUM_SRC sources
module axi_fifo_rr_arbiter #(
  parameter int FIFO_WIDTH = 2,
  parameter int NUM_SRC    = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic                            aclk,
  input  logic                            rst,
  input  logic [NUM_SRC*8*FIFO_WIDTH-1:0] iAXI_data,
  input  logic [NUM_SRC-1:0]              iAXI_valid,
  input  logic [NUM_SRC-1:0]              iAXI_tuser,
  output logic [NUM_SRC-1:0]              iAXI_ready,
  output logic [8*FIFO_WIDTH-1:0]         oAXI_data,
  output logic                            oAXI_valid,
  output logic                            oAXI_tuser,
  input  logic                            oAXI_ready,
  input  logic [NUM_SRC-1:0]              src_en,
  output logic [$clog2(NUM_SRC)-1:0]      grant_id,
  output logic                            busy
);
  localparam int W  = 8*FIFO_WIDTH;
  localparam int IW = $clog2(NUM_SRC);
  localparam int CW = $clog2(MAX_BURST+1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t             state_q;
  logic [IW-1:0]      grant_q, last_q, pick;
  logic [CW-1:0]      cnt_q;
  logic [NUM_SRC-1:0] req;
  logic               gnt, vg, tg, beat;
  int                 j;
  assign req        = iAXI_valid & src_en;
  assign gnt        = state_q == GRANT;
  assign vg         = iAXI_valid[grant_q];
  assign tg         = iAXI_tuser[grant_q];
  assign beat       = gnt && vg && oAXI_ready;
  assign oAXI_valid = gnt && vg;
  assign oAXI_tuser = gnt && tg;
  assign oAXI_data  = gnt ? iAXI_data[grant_q*W +: W] : '0;
  assign iAXI_ready = (gnt && oAXI_ready) ? NUM_SRC'(1) << grant_q : '0;
  assign grant_id   = grant_q;
  assign busy       = gnt;
  // first requester after last_q with wrap; scanning downward lets the nearest one win
  always_comb begin
    pick = last_q;
    j = 0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      j = (int'(last_q) + i) % NUM_SRC;
      if (req[IW'(j)]) pick = IW'(j);
    end
  end
  // arbitration state: grant in IDLE, count beats and release the burst in GRANT
  always_ff @(posedge aclk) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= IW'(NUM_SRC-1);
      grant_q <= '0;
      cnt_q   <= '0;
    end else if (!gnt) begin
      if (|req) begin
        state_q <= GRANT;
        grant_q <= pick;
        last_q  <= pick;
        cnt_q   <= '0;
      end
    end else if (!vg) begin
      state_q <= IDLE;
    end else if (beat) begin
      cnt_q <= cnt_q + 1'b1;
      if (tg || cnt_q == CW'(MAX_BURST-1)) state_q <= IDLE;
    end
  end
endmodule

// File: tb/tb_axi_fifo_rr_arbiter.sv
// tb_axi_fifo_rr_arbiter: directed checks of grant order, burst cap, backpressure, masking and reset
module tb_axi_fifo_rr_arbiter;
  logic        aclk, rst, oAXI_ready, oAXI_valid, oAXI_tuser, busy;
  logic [63:0] iAXI_data;
  logic [3:0]  iAXI_valid, iAXI_tuser, iAXI_ready, src_en;
  logic [15:0] oAXI_data;
  logic [1:0]  grant_id;
  logic [15:0] mem [4][16];
  logic [15:0] tus [4];
  int          len [4];
  int          idx [4];
  int          lg_gid [64];
  int          lg_dat [64];
  int          lg_tu  [64];
  int          lg_cyc [64];
  int          lg_n, cyc, n_chk, n_pass;

  axi_fifo_rr_arbiter #(.FIFO_WIDTH(2), .NUM_SRC(4), .MAX_BURST(4)) dut (
    .aclk(aclk), .rst(rst), .iAXI_data(iAXI_data), .iAXI_valid(iAXI_valid),
    .iAXI_tuser(iAXI_tuser), .iAXI_ready(iAXI_ready), .oAXI_data(oAXI_data),
    .oAXI_valid(oAXI_valid), .oAXI_tuser(oAXI_tuser), .oAXI_ready(oAXI_ready),
    .src_en(src_en), .grant_id(grant_id), .busy(busy)
  );

  initial begin
    aclk = 0;
    forever #5 aclk = ~aclk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  task automatic drive();
    for (int k = 0; k < 4; k++) begin
      logic v;
      v = idx[k] < len[k];
      iAXI_valid[k] = v;
      iAXI_data[k*16 +: 16] = v ? mem[k][idx[k][3:0]] : 16'h0;
      iAXI_tuser[k] = v ? tus[k][idx[k][3:0]] : 1'b0;
    end
  endtask

  task automatic step();
    logic [3:0] hs;
    @(negedge aclk);
    hs = iAXI_valid & iAXI_ready;
    if (oAXI_valid === 1'b1 && oAXI_ready && lg_n < 64) begin
      lg_gid[lg_n] = int'(grant_id);
      lg_dat[lg_n] = int'(oAXI_data);
      lg_tu[lg_n]  = int'(oAXI_tuser);
      lg_cyc[lg_n] = cyc;
      lg_n++;
    end
    @(posedge aclk);
    #1;
    cyc++;
    for (int k = 0; k < 4; k++) if (hs[k] === 1'b1) idx[k]++;
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input int k, input int n, input int base, input logic [15:0] tm);
    for (int i = 0; i < 16; i++) mem[k][i] = 16'(base + i);
    len[k] = n;
    idx[k] = 0;
    tus[k] = tm;
  endtask

  task automatic do_reset();
    rst = 0;
    for (int k = 0; k < 4; k++) load(k, 0, 0, 16'h0);
    drive();
    run(2);
    rst = 1;
    lg_n = 0;
  endtask

  task automatic exp_beat(input string t, input int i, input int g, input int d, input int tu);
    chk($sformatf("%s_b%0d_gid", t, i), 32'(lg_gid[i]), 32'(g));
    chk($sformatf("%s_b%0d_dat", t, i), 32'(lg_dat[i]), 32'(d));
    chk($sformatf("%s_b%0d_tu", t, i), 32'(lg_tu[i]), 32'(tu));
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; lg_n = 0;
    rst = 0; oAXI_ready = 1; src_en = 4'hF;
    iAXI_data = '0; iAXI_valid = '0; iAXI_tuser = '0;
    do_reset();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(iAXI_ready), 0);
    chk("rst_valid", 32'(oAXI_valid), 0);
    chk("rst_data", 32'(oAXI_data), 0);
    chk("rst_gid", 32'(grant_id), 0);

    load(1, 3, 0, 16'b100);
    mem[1][0] = 16'h0011; mem[1][1] = 16'h0022; mem[1][2] = 16'h0033;
    drive();
    chk("t1_idle", 32'(busy), 0);
    step();
    chk("t1_gid", 32'(grant_id), 1);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_dat0", 32'(oAXI_data), 32'h11);
    chk("t1_rdy", 32'(iAXI_ready), 32'b0010);
    run(3);
    chk("t1_end_busy", 32'(busy), 0);
    chk("t1_end_valid", 32'(oAXI_valid), 0);
    chk("t1_n", 32'(lg_n), 3);
    exp_beat("t1", 0, 1, 16'h11, 0);
    exp_beat("t1", 1, 1, 16'h22, 0);
    exp_beat("t1", 2, 1, 16'h33, 1);

    do_reset();
    for (int k = 0; k < 4; k++) load(k, 2, k*16, 16'hFFFF);
    drive();
    run(18);
    chk("t2_n", 32'(lg_n), 8);
    for (int i = 0; i < 8; i++) exp_beat("t2", i, i % 4, (i % 4)*16 + i/4, 1);
    for (int i = 1; i < 8; i++) chk($sformatf("t2_gap%0d", i), 32'(lg_cyc[i] - lg_cyc[i-1]), 2);

    do_reset();
    load(2, 10, 16'h200, 16'h0);
    drive();
    step();
    load(0, 1, 16'hAA, 16'h1);
    drive();
    run(20);
    chk("t3_n", 32'(lg_n), 11);
    for (int i = 0; i < 4; i++) exp_beat("t3", i, 2, 16'h200 + i, 0);
    exp_beat("t3", 4, 0, 16'hAA, 1);
    for (int i = 5; i < 11; i++) exp_beat("t3", i, 2, 16'h200 + i - 1, 0);
    chk("t3_idle", 32'(busy), 0);

    do_reset();
    load(1, 4, 16'h40, 16'b1000);
    drive();
    run(3);
    oAXI_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t4_dat%0d", i), 32'(oAXI_data), 32'h42);
      chk($sformatf("t4_rdy%0d", i), 32'(iAXI_ready), 0);
      chk($sformatf("t4_vld%0d", i), 32'(oAXI_valid), 1);
      chk($sformatf("t4_busy%0d", i), 32'(busy), 1);
    end
    oAXI_ready = 1;
    run(5);
    chk("t4_n", 32'(lg_n), 4);
    for (int i = 0; i < 4; i++) exp_beat("t4", i, 1, 16'h40 + i, i == 3 ? 1 : 0);
    chk("t4_gap", 32'(lg_cyc[3] - lg_cyc[2]), 1);
    chk("t4_idle", 32'(busy), 0);

    do_reset();
    src_en = 4'b1010;
    for (int k = 0; k < 4; k++) load(k, 3, k*16, 16'hFFFF);
    drive();
    run(14);
    chk("t5a_n", 32'(lg_n), 6);
    for (int i = 0; i < 6; i++) exp_beat("t5a", i, i % 2 ? 3 : 1, (i % 2 ? 16'h30 : 16'h10) + i/2, 1);
    lg_n = 0;
    load(1, 6, 16'h10, 16'h0);
    load(3, 6, 16'h30, 16'h0);
    drive();
    run(2);
    src_en = 4'b1000;
    run(16);
    chk("t5b_n", 32'(lg_n), 10);
    for (int i = 0; i < 4; i++) exp_beat("t5b", i, 1, 16'h10 + i, 0);
    for (int i = 4; i < 10; i++) exp_beat("t5b", i, 3, 16'h30 + i - 4, 0);
    chk("t5b_idle", 32'(busy), 0);
    chk("t5b_left", 32'(idx[1]), 4);

    do_reset();
    src_en = 4'hF;
    load(3, 4, 16'h300, 16'h0);
    drive();
    run(2);
    chk("t6_pre_busy", 32'(busy), 1);
    rst = 0;
    step();
    chk("t6_busy", 32'(busy), 0);
    chk("t6_ready", 32'(iAXI_ready), 0);
    chk("t6_valid", 32'(oAXI_valid), 0);
    chk("t6_data", 32'(oAXI_data), 0);
    chk("t6_tuser", 32'(oAXI_tuser), 0);
    rst = 1;
    for (int k = 0; k < 4; k++) load(k, 1, k*16, 16'h1);
    drive();
    step();
    chk("t6_gid", 32'(grant_id), 0);
    chk("t6_gbusy", 32'(busy), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
